// File: rtl/qdiv_f_seq.sv
// Iterative IEEE 754 single-precision divider (result = a / b).
// Produces one restoring-division quotient bit per clock and takes one operation
// at a time over a valid/ready handshake. Rounding truncates toward zero, and
// subnormal operands and results are flushed to zero.
//
// Handshake: an operation is taken on the rising edge where valid_i && ready_o.
// ready_o is high only in IDLE. valid_i seen while busy is ignored and nothing
// is queued. valid_o is a one-cycle pulse in DONE, and result_o/div_by_zero_o
// are valid with that pulse. They hold their value until the next DONE.
module qdiv_f_seq #(
  parameter int I    = 9,
  parameter int F    = 23,
  parameter int BIAS = 127
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           valid_i,
  output logic           ready_o,
  input  logic [I+F-1:0] a_i,
  input  logic [I+F-1:0] b_i,
  output logic           valid_o,
  output logic [I+F-1:0] result_o,
  output logic           div_by_zero_o,
  output logic [2:0]     dbg_state
);

  localparam int W     = I + F;       // word width
  localparam int EW    = I - 1;       // exponent field width
  localparam int MW    = F + 1;       // mantissa width with hidden one
  localparam int RW    = F + 2;       // remainder / quotient width
  localparam int EXW   = EW + 2;      // signed exponent working width
  localparam int NITER = F + 2;       // quotient bits produced
  localparam int CW    = $clog2(NITER + 1);
  localparam int EMAX  = (1 << EW) - 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_DIV   = 3'd2,
    S_NORM  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [RW-1:0]   rem;
  logic [RW-1:0]   quo;
  logic [CW-1:0]   cnt;
  logic            sign_q;

  // Field decode of the captured operands
  logic            sa, sb;
  logic [EW-1:0]   ea, eb;
  logic [F-1:0]    fa, fb;
  logic            a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  // Division step and normalisation results
  logic            rem_ge;
  logic [RW-1:0]   rem_sub;
  logic [RW-1:0]   rem_next;
  logic [F-1:0]    frac_n;
  logic signed [EXW-1:0] e_norm;
  logic [W-1:0]    norm_result;

  // Special-case classification
  logic            is_special;
  logic [W-1:0]    special_result;
  logic            special_dbz;

  localparam logic [W-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(F-1){1'b0}}};

  assign dbg_state = state;

  // Operand field decode and class flags; an all-zero exponent means zero
  always_comb begin
    sa     = a_q[W-1];
    sb     = b_q[W-1];
    ea     = a_q[W-2:F];
    eb     = b_q[W-2:F];
    fa     = a_q[F-1:0];
    fb     = b_q[F-1:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == {EW{1'b1}}) && (fa == '0);
    b_inf  = (eb == {EW{1'b1}}) && (fb == '0);
    a_nan  = (ea == {EW{1'b1}}) && (fa != '0);
    b_nan  = (eb == {EW{1'b1}}) && (fb != '0);
  end

  // Special-case result selection, highest priority first
  always_comb begin
    is_special     = 1'b1;
    special_result = '0;
    special_dbz    = 1'b0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      special_result = QNAN;
    end else if (a_inf) begin
      special_result = {sa ^ sb, {EW{1'b1}}, {F{1'b0}}};
    end else if (b_zero) begin
      special_result = {sa ^ sb, {EW{1'b1}}, {F{1'b0}}};
      special_dbz    = 1'b1;
    end else if (a_zero || b_inf) begin
      special_result = {sa ^ sb, {(W-1){1'b0}}};
    end else begin
      is_special = 1'b0;
    end
  end

  // One restoring step: subtract the divisor when it fits, then shift left
  always_comb begin
    rem_ge   = (rem >= {1'b0, 1'b1, fb});
    rem_sub  = rem_ge ? (rem - {1'b0, 1'b1, fb}) : rem;
    rem_next = {rem_sub[RW-2:0], 1'b0};
  end

  // Normalise the quotient, rebias the exponent and clamp overflow/underflow
  always_comb begin
    frac_n = quo[RW-1] ? quo[RW-2:1] : quo[RW-3:0];
    e_norm = EXW'({2'b00, ea}) - EXW'({2'b00, eb}) + EXW'(BIAS)
           - EXW'(quo[RW-1] ? 0 : 1);
    if (e_norm >= $signed(EXW'(EMAX))) begin
      norm_result = {sign_q, {EW{1'b1}}, {F{1'b0}}};
    end else if (e_norm <= $signed(EXW'(0))) begin
      norm_result = {sign_q, {(W-1){1'b0}}};
    end else begin
      norm_result = {sign_q, e_norm[EW-1:0], frac_n};
    end
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      ready_o       <= 1'b1;
      valid_o       <= 1'b0;
      result_o      <= '0;
      div_by_zero_o <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      rem           <= '0;
      quo           <= '0;
      cnt           <= '0;
      sign_q        <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (valid_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            ready_o <= 1'b0;
            state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          sign_q <= sa ^ sb;
          if (is_special) begin
            result_o      <= special_result;
            div_by_zero_o <= special_dbz;
            valid_o       <= 1'b1;
            state         <= S_DONE;
          end else begin
            rem   <= {1'b0, 1'b1, fa};
            quo   <= '0;
            cnt   <= '0;
            state <= S_DIV;
          end
        end
        S_DIV: begin
          rem <= rem_next;
          quo <= {quo[RW-2:0], rem_ge};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(NITER - 1)) begin
            state <= S_NORM;
          end
        end
        S_NORM: begin
          result_o      <= norm_result;
          div_by_zero_o <= 1'b0;
          valid_o       <= 1'b1;
          state         <= S_DONE;
        end
        S_DONE: begin
          ready_o <= 1'b1;
          state   <= S_IDLE;
        end
        default: begin
          ready_o <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qdiv_f_seq.sv
// Bench for qdiv_f_seq: directed operand pairs with hand-computed quotients.
// The driver pushes each expected result and its due cycle into queues, and a
// monitor on the falling edge pops and compares them whenever valid_o is seen.
module tb_qdiv_f_seq;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         valid_o;
  logic [W-1:0] result_o;
  logic         dbz_o;
  logic [2:0]   dbg_state;

  logic [W:0]   exp_q[$];    // {div_by_zero, result}
  int           exp_cyc_q[$];
  int           cyc;
  int           total;
  int           bad;

  qdiv_f_seq #(.I(9), .F(23), .BIAS(127)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .a_i           (a_i),
    .b_i           (b_i),
    .valid_o       (valid_o),
    .result_o      (result_o),
    .div_by_zero_o (dbz_o),
    .dbg_state     (dbg_state)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a result
  always @(negedge clk) begin
    if (!rst && valid_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 64'(result_o), 64'hDEAD);
      end else begin
        logic [W:0] e;
        int ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("result", 64'(result_o), 64'(e[W-1:0]));
        check("dbz", 64'(dbz_o), 64'(e[W]));
        check("latency_cycle", 64'(cyc), 64'(ec));
        check("ready_in_done", 64'(ready_o), 64'd0);
      end
    end
  end

  // driver: wait for ready, present one op for one cycle, record expectation
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] res, input logic dbz, input int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) check("ready_timeout", 64'(ready_o), 64'd1);
    valid_i = 1'b1;
    a_i     = a;
    b_i     = b;
    exp_q.push_back({dbz, res});
    exp_cyc_q.push_back(cyc + lat);
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  initial begin
    int n;
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    valid_i = 1'b0;
    a_i     = '0;
    b_i     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_result", 64'(result_o), 64'd0);
    check("rst_dbz", 64'(dbz_o), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);

    // normal quotients
    do_op(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 28); // 6/2
    do_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 28); // 1/3
    do_op(32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 28); // -6/2
    do_op(32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 28); // 1/1
    do_op(32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0, 28); // overflow
    do_op(32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 28); // underflow
    // special cases
    do_op(32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 2);  // 1/0
    do_op(32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 2);  // -1/0
    do_op(32'h80000000, 32'h00000000, 32'h7FC00000, 1'b0, 2);  // -0/0
    do_op(32'h7F800001, 32'h3F800000, 32'h7FC00000, 1'b0, 2);  // NaN/1
    do_op(32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0, 2);  // inf/inf
    do_op(32'h7F800000, 32'hC0000000, 32'hFF800000, 1'b0, 2);  // inf/-2
    do_op(32'h00000000, 32'h40A00000, 32'h00000000, 1'b0, 2);  // 0/5
    do_op(32'h3F800000, 32'hFF800000, 32'h80000000, 1'b0, 2);  // 1/-inf
    do_op(32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 2);  // subnormal/1
    do_op(32'h7F800000, 32'h00000000, 32'h7F800000, 1'b0, 2);  // inf/0

    // valid_i held high with new operands while busy: must be ignored
    n = 0;
    @(negedge clk);
    while (!ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    valid_i = 1'b1;
    a_i     = 32'h40C00000;
    b_i     = 32'h40000000;
    exp_q.push_back({1'b0, 32'h40400000});
    exp_cyc_q.push_back(cyc + 28);
    for (int k = 1; k <= 27; k++) begin
      @(negedge clk);
      a_i = 32'h3F800000 + 32'(k);
      b_i = 32'h40400000;
    end
    @(negedge clk);                 // cycle 28: DONE
    valid_i = 1'b0;
    @(negedge clk);                 // cycle 29: idle again
    check("ready_after_done", 64'(ready_o), 64'd1);
    valid_i = 1'b1;
    a_i     = 32'h3F800000;
    b_i     = 32'h40400000;
    exp_q.push_back({1'b0, 32'h3EAAAAAA});
    exp_cyc_q.push_back(cyc + 28);  // lands in cycle 57 of the first op
    @(negedge clk);
    valid_i = 1'b0;

    // reset in cycle 10 of a normal op: op abandoned, no valid_o ever
    n = 0;
    @(negedge clk);
    while (!ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    valid_i = 1'b1;
    a_i     = 32'h40C00000;
    b_i     = 32'h40000000;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (9) @(negedge clk);      // now in cycle 10
    rst = 1'b1;
    @(negedge clk);                 // cycle 11
    rst = 1'b0;
    check("midrst_ready", 64'(ready_o), 64'd1);
    check("midrst_valid", 64'(valid_o), 64'd0);
    check("midrst_result", 64'(result_o), 64'd0);
    repeat (40) @(negedge clk);     // monitor flags any stray valid_o

    // one more op after the abandoned one
    do_op(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 28);

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
